// File: rtl/vend_session_arbiter.sv
// Session arbiter sharing one vending_machine core between several front panels.
// A round-robin grant gives one panel the core per session. The granted panel's card and
// keypad are muxed onto the core. A session ends on a core outcome, a card pull or an
// inactivity timeout. A fixed drain gap follows, and operator reload windows are taken
// between sessions.
module vend_session_arbiter #(
  parameter int unsigned N_PANELS  = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_PANELS-1:0]   REQ,
  input  logic [N_PANELS-1:0]   PANEL_KEY,
  input  logic [4*N_PANELS-1:0] PANEL_CODE,
  input  logic                  RELOAD_REQ,
  input  logic                  CORE_VEND,
  input  logic                  CORE_INVALID_SEL,
  input  logic                  CORE_FAILED_TRAN,
  output logic                  CORE_CARD_IN,
  output logic                  CORE_KEY_PRESS,
  output logic [3:0]            CORE_ITEM_CODE,
  output logic                  CORE_RELOAD,
  output logic [N_PANELS-1:0]   GRANT,
  output logic [IDX_W-1:0]      GRANT_IDX,
  output logic                  SESSION_DONE,
  output logic [2:0]            END_CAUSE
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);
  localparam logic [2:0] DrainLast  = 3'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {StIdle, StActive, StDrain, StReload} state_e;

  state_e state_q, state_d;

  logic [N_PANELS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [7:0]          timer_q, timer_d;
  logic                vend_seen_q, vend_seen_d;
  logic [2:0]          drain_cnt_q, drain_cnt_d;
  logic                session_done_q, session_done_d;
  logic [2:0]          end_cause_q, end_cause_d;

  logic                req_any;
  logic                found_hi, found_lo;
  logic [IDX_W-1:0]    idx_hi, idx_lo, winner_idx;
  logic                card_sel, key_sel;
  logic [3:0]          code_sel;
  logic                end_any;
  logic [2:0]          end_code;
  logic                drain_last;

  assign req_any    = |REQ;
  assign drain_last = (drain_cnt_q == DrainLast);

  // Round-robin pick: lowest requester above the pointer, else lowest requester overall (wrap).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < N_PANELS; i++) begin
      if (REQ[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = IDX_W'(i);
      end
      if (REQ[i] && (i > int'(ptr_q)) && !found_hi) begin
        found_hi = 1'b1;
        idx_hi   = IDX_W'(i);
      end
    end
    winner_idx = found_hi ? idx_hi : idx_lo;
  end

  // Select the granted panel's card, key and code digit.
  always_comb begin
    card_sel = 1'b0;
    key_sel  = 1'b0;
    code_sel = '0;
    for (int i = 0; i < N_PANELS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        card_sel = REQ[i];
        key_sel  = PANEL_KEY[i];
        code_sel = PANEL_CODE[4*i +: 4];
      end
    end
  end

  // Session end detection; earlier branches win when several causes coincide.
  always_comb begin
    end_any  = 1'b0;
    end_code = 3'd0;
    if (state_q == StActive) begin
      end_any = 1'b1;
      if (CORE_FAILED_TRAN) begin
        end_code = 3'd2;
      end else if (CORE_INVALID_SEL) begin
        end_code = 3'd1;
      end else if (vend_seen_q && !CORE_VEND) begin
        end_code = 3'd0;
      end else if (!card_sel) begin
        end_code = 3'd3;
      end else if (timer_q == TimeoutVal) begin
        end_code = 3'd4;
      end else begin
        end_any = 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; reload wins over panel requests when idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (RELOAD_REQ) begin
          state_d = StReload;
        end else if (req_any) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (end_any) state_d = StDrain;
      end
      StDrain: begin
        if (drain_last) state_d = RELOAD_REQ ? StReload : StIdle;
      end
      StReload: begin
        if (!RELOAD_REQ) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Session datapath next-state: grant, pointer, inactivity timer, drain counter, end report.
  always_comb begin
    grant_d        = grant_q;
    grant_idx_d    = grant_idx_q;
    ptr_d          = ptr_q;
    timer_d        = timer_q;
    vend_seen_d    = vend_seen_q;
    drain_cnt_d    = drain_cnt_q;
    session_done_d = 1'b0;
    end_cause_d    = end_cause_q;
    case (state_q)
      StIdle: begin
        if (!RELOAD_REQ && req_any) begin
          grant_d             = '0;
          grant_d[winner_idx] = 1'b1;
          grant_idx_d         = winner_idx;
          ptr_d               = winner_idx;
          timer_d             = '0;
          vend_seen_d         = 1'b0;
        end
      end
      StActive: begin
        if (end_any) begin
          session_done_d = 1'b1;
          end_cause_d    = end_code;
          grant_d        = '0;
          drain_cnt_d    = '0;
        end else begin
          if (CORE_VEND) vend_seen_d = 1'b1;
          if (key_sel || CORE_VEND) begin
            timer_d = '0;
          end else if (timer_q != TimeoutVal) begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q + 3'd1;
      end
      default: ;
    endcase
  end

  // Session datapath registers; the pointer resets to the last panel so panel 0 wins first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      grant_q        <= '0;
      grant_idx_q    <= '0;
      ptr_q          <= IDX_W'(N_PANELS - 1);
      timer_q        <= '0;
      vend_seen_q    <= 1'b0;
      drain_cnt_q    <= '0;
      session_done_q <= 1'b0;
      end_cause_q    <= '0;
    end else begin
      grant_q        <= grant_d;
      grant_idx_q    <= grant_idx_d;
      ptr_q          <= ptr_d;
      timer_q        <= timer_d;
      vend_seen_q    <= vend_seen_d;
      drain_cnt_q    <= drain_cnt_d;
      session_done_q <= session_done_d;
      end_cause_q    <= end_cause_d;
    end
  end

  // Core-facing outputs: live mux during a session, reload strobe in the window, else quiet.
  always_comb begin
    CORE_CARD_IN   = 1'b0;
    CORE_KEY_PRESS = 1'b0;
    CORE_ITEM_CODE = '0;
    CORE_RELOAD    = 1'b0;
    case (state_q)
      StActive: begin
        CORE_CARD_IN   = card_sel;
        CORE_KEY_PRESS = key_sel;
        CORE_ITEM_CODE = code_sel;
      end
      StReload: CORE_RELOAD = 1'b1;
      default: ;
    endcase
  end

  assign GRANT        = grant_q;
  assign GRANT_IDX    = grant_idx_q;
  assign SESSION_DONE = session_done_q;
  assign END_CAUSE    = end_cause_q;

endmodule
